count_dir_ctrl: RTL and testbench
=================================

# count_dir_ctrl

Direction controller that drives the mode input `m` of the 3-bit up/down counter and sits directly upstream of it. It debounces a push-button that manually reverses counting direction. In auto mode it also watches the counter's `q` feedback and reverses direction at the terminal values, so the counter ping-pongs 0→7→0. It runs on the same clock as the counter, which counts on every edge.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples needed before a button level change is accepted. Legal range 1–255.

Ports:
- `clk`  in  1  system clock, shared with the counter.
- `clr`  in  1  reset; asynchronous, active-high.
- `btn`  in  1  raw, asynchronous direction push-button, active-high.
- `auto_en`  in  1  1 = automatic reversal at terminal counts; 0 = manual only. Synchronous level.
- `q`  in  3  current counter value (feedback).
- `m`  out  1  counter mode: 0 = count up, 1 = count down.
- `dir_chg`  out  1  one-cycle pulse in the cycle after `m` changes.
- `btn_db`  out  1  debounced button level, for observation.

## Operation
- Reset (`clr`=1, any time, including mid-debounce or mid-sweep):
  - FSM goes to S_UP, so `m`=0.
  - `dir_chg`=0 and `btn_db`=0.
  - Both synchronizer flops=0 and the debounce counter=0.
- Synchronizer: `btn` passes through 2 flops to give `btn_s`.
- Debounce:
  - If `btn_s`==`btn_db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 while still mismatched, `btn_db` takes `btn_s` at that edge and the counter clears.
  - The counter width is sized to hold DEBOUNCE_CYCLES−1 and must never wrap.
- `press` = `btn_db` rising edge, combinational from `btn_db` and its 1-cycle delayed copy. Release is ignored.
- FSM states S_UP (`m`=0) and S_DOWN (`m`=1). `m` is a registered state decode.
- `auto_flip` logic (`q` is combinational input; `m` updates at the same edge the counter samples the old `m`):
  - In S_UP, `auto_flip` = `auto_en` && `q`==3'd6.
  - In S_DOWN, `auto_flip` = `auto_en` && `q`==3'd1.
  - Effect: the counter reaches 7 (or 0) and then immediately reverses.
- Transition rule: if `press` || `auto_flip`, go to the other state; otherwise hold. If both occur in the same cycle, the state toggles exactly once.
- `dir_chg` is registered: it is 1 in the cycle after any transition, otherwise 0.
- When `auto_en`=0 and `q` sits at a terminal value, no action is taken; the counter wraps naturally.

## Timing
- From `btn` going high and staying stable:
  - `btn_s` is high after 2 edges.
  - `btn_db` is high after 2+DEBOUNCE_CYCLES edges.
  - `m` toggles at the next edge, edge 3+DEBOUNCE_CYCLES.
  - `dir_chg` pulses for one cycle after that.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no `btn_db` change.
- Auto reversal has zero added latency: `m` changes at the same edge that the counter moves to the terminal value.
- Reset assertion is asynchronous. On deassertion, the first active edge is the first edge after `clr` falls.

## Structure
- Shared package `updown_pkg`:
  - `DIR_UP`=1'b0, `DIR_DN`=1'b1.
  - The 1-bit state encoding S_UP/S_DOWN.
  - Terminal-predecessor constants `Q_TURN_UP`=3'd6 and `Q_TURN_DN`=3'd1.
- Sub-module `btn_debounce`: synchronizer, debounce counter, edge detect. Parameter DEBOUNCE_CYCLES; outputs `btn_db` and `press`. It is reusable for other panel buttons.
- The top level contains the FSM, auto-flip decode and `dir_chg` register.
- Bench: instantiate this block with the counter in closed loop.

## Test plan
- Reset: `clr`=1 mid-sweep with `m`=1 → `m`=0, `dir_chg`=0 and `btn_db`=0 immediately. After release, the counter counts up from 0.
- Auto ping-pong: `auto_en`=1, 20 clocks after reset → `q` = 0,1,…,7,6,…,0,1,… and `dir_chg` pulses after `q`=7 and after `q`=0.
- Manual press, DEBOUNCE_CYCLES=4, `auto_en`=0: `btn` high for 10 cycles → `m` 0→1 exactly at edge 7 after `btn` rises, and one `dir_chg` pulse. Release → no change.
- Glitch rejection: `btn` high for 3 synchronized cycles, then low → `btn_db` stays 0 and `m` is unchanged.
- Collision: align `press` with `auto_en`=1, `q`=6 in S_UP → a single toggle to S_DOWN, one `dir_chg` pulse, and `q` continues 7,6.
- Manual wrap: `auto_en`=0 and `m`=0 → `q` goes 7→0 with no direction change and no `dir_chg`.

Source files
------------

// File: rtl/updown_pkg.sv
// ---------------------------------------------------------------------------
// updown_pkg
//
// Shared definitions for the 3-bit up/down counter and its direction
// controller.
//
//   DIR_UP / DIR_DN     : values of the counter mode input m
//   S_UP / S_DOWN       : 1-bit direction FSM state encoding
//   Q_TURN_UP/Q_TURN_DN : counter values one step before a terminal value;
//                         reversing when q sits here makes the counter land
//                         on 7 (or 0) and then immediately come back.
// ---------------------------------------------------------------------------
package updown_pkg;

    // Counter mode encoding
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

    // Direction FSM state encoding
    localparam logic [0:0] S_UP   = 1'b0;
    localparam logic [0:0] S_DOWN = 1'b1;

    // Terminal-predecessor counter values
    localparam logic [2:0] Q_TURN_UP = 3'd6;
    localparam logic [2:0] Q_TURN_DN = 3'd1;

    // Opposite direction state
    function automatic logic [0:0] other_state(input logic [0:0] s);
        return (s == S_UP) ? S_DOWN : S_UP;
    endfunction

    // Mode value the counter sees in a given state
    function automatic logic state_to_dir(input logic [0:0] s);
        return (s == S_DOWN) ? DIR_DN : DIR_UP;
    endfunction

endpackage : updown_pkg

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Push-button conditioner: two-flop synchronizer, level debouncer and
// rising-edge detector. Reusable for any active-high panel button.
//
// A level change on the synchronized button is accepted only after it has
// differed from the current debounced level for DEBOUNCE_CYCLES consecutive
// clock edges. Any return to the debounced level restarts the count.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable samples required to accept a change (1..255)
//
// Ports:
//   clk    in   system clock
//   clr    in   asynchronous active-high reset
//   btn    in   raw asynchronous button, active-high
//   btn_db out  debounced button level
//   press  out  one-cycle pulse on the debounced rising edge (combinational)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    // Wide enough for DEBOUNCE_CYCLES-1; the counter clears on reaching that
    // value, so it never wraps.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             db_q;
    logic             db_d;
    logic             db_dly_q;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;

    // Debounce: count edges on which btn_s disagrees with the debounced
    // level. The edge that finds the count at DEBOUNCE_CYCLES-1 is the
    // DEBOUNCE_CYCLES-th mismatched sample, so the new level is taken there.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (btn_s == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = btn_s;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            db_q     <= 1'b0;
            db_dly_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_q;
        end
    end

    assign btn_db = db_q;
    // Only the rising edge matters; release is ignored downstream.
    assign press  = db_q & ~db_dly_q;

endmodule : btn_debounce

// File: rtl/count_dir_ctrl.sv
// ---------------------------------------------------------------------------
// count_dir_ctrl
//
// Direction controller feeding the mode input of a 3-bit up/down counter.
// A debounced push-button reverses direction manually; with auto_en set the
// controller also reverses at the terminal counts so the counter ping-pongs
// 0..7..0.
//
// Parameters:
//   DEBOUNCE_CYCLES : button debounce length in clock edges (1..255)
//
// Ports:
//   clk      in   system clock, shared with the counter
//   clr      in   asynchronous active-high reset
//   btn      in   raw asynchronous direction button, active-high
//   auto_en  in   1 = automatic reversal at terminal counts
//   q[2:0]   in   counter value feedback
//   m        out  counter mode: 0 = up, 1 = down (registered state decode)
//   dir_chg  out  one-cycle pulse in the cycle after m changes
//   btn_db   out  debounced button level
// ---------------------------------------------------------------------------
module count_dir_ctrl
    import updown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn,
    input  logic       auto_en,
    input  logic [2:0] q,
    output logic       m,
    output logic       dir_chg,
    output logic       btn_db
);

    logic       press;
    logic       auto_flip;
    logic       flip;
    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       dir_chg_q;
    logic       dir_chg_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .clr    (clr),
        .btn    (btn),
        .btn_db (btn_db),
        .press  (press)
    );

    // The counter samples the old m at the same edge our state updates, so
    // turning one count early lets the counter land on the terminal value
    // while m already points back the other way.
    always_comb begin
        auto_flip = 1'b0;
        if (auto_en) begin
            if (state_q == S_UP) begin
                auto_flip = (q == Q_TURN_UP);
            end else begin
                auto_flip = (q == Q_TURN_DN);
            end
        end
    end

    // A press coinciding with an auto turn still toggles only once.
    assign flip = press | auto_flip;

    always_comb begin
        state_d   = state_q;
        dir_chg_d = 1'b0;
        if (flip) begin
            state_d   = other_state(state_q);
            dir_chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_UP;
            dir_chg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_chg_q <= dir_chg_d;
        end
    end

    assign m       = state_to_dir(state_q);
    assign dir_chg = dir_chg_q;

endmodule : count_dir_ctrl

// File: tb/tb_count_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_dir_ctrl
//
// Closed-loop bench: count_dir_ctrl drives a behavioural 3-bit up/down
// counter whose value is fed back on q. A system-level reference model
// tracks button filtering, direction and count, and every clock the DUT
// outputs and the counter are compared against it.
// ---------------------------------------------------------------------------
module tb_count_dir_ctrl;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       btn;
    logic       auto_en;
    logic [2:0] cnt;
    logic       m;
    logic       dir_chg;
    logic       btn_db;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_s1, m_s2;      // button as seen 1 and 2 edges ago
    bit m_db, m_db_prev; // debounced level now / one edge ago
    int m_run;           // consecutive edges btn_s disagreed with m_db
    bit m_dir;           // 0 = up
    bit m_chg;
    int m_q;

    always #5 clk = ~clk;

    count_dir_ctrl #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .btn     (btn),
        .auto_en (auto_en),
        .q       (cnt),
        .m       (m),
        .dir_chg (dir_chg),
        .btn_db  (btn_db)
    );

    // The counter under control
    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt <= 3'd0;
        else     cnt <= m ? cnt - 3'd1 : cnt + 3'd1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0;
        m_run = 0; m_dir = 0; m_chg = 0; m_q = 0;
    endtask

    // One clock edge of the whole closed loop, from pre-edge values.
    task automatic model_edge();
        bit press_now, turn, flip;
        press_now = m_db && !m_db_prev;
        // reverse when the upcoming count would be a terminal value
        turn = auto_en && ((!m_dir && m_q + 1 == 7) || (m_dir && m_q - 1 == 0));
        flip = press_now || turn;
        m_q = m_dir ? (m_q + 7) % 8 : (m_q + 1) % 8;
        m_chg = flip;
        if (flip) m_dir = !m_dir;
        m_db_prev = m_db;
        if (m_s2 != m_db) begin
            m_run++;
            if (m_run == DC) begin
                m_db  = m_s2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    // Advance one clock and compare everything on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!clr) model_edge();
        @(negedge clk);
        check("m", {7'd0, m}, {7'd0, m_dir});
        check("dir_chg", {7'd0, dir_chg}, {7'd0, m_chg});
        check("btn_db", {7'd0, btn_db}, {7'd0, m_db});
        check("q", {5'd0, cnt}, m_q[7:0]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Mid-cycle asynchronous reset; outputs must clear before any edge.
    task automatic do_reset();
        @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("rst_m", {7'd0, m}, 8'd0);
        check("rst_dir_chg", {7'd0, dir_chg}, 8'd0);
        check("rst_btn_db", {7'd0, btn_db}, 8'd0);
        check("rst_q", {5'd0, cnt}, 8'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        int pp;
        logic m_before;
        clr = 1'b1; btn = 1'b0; auto_en = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("init_m", {7'd0, m}, 8'd0);
        check("init_dir_chg", {7'd0, dir_chg}, 8'd0);
        check("init_btn_db", {7'd0, btn_db}, 8'd0);
        clr = 1'b0;

        // Auto ping-pong: q after k edges follows a triangle of period 14
        auto_en = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            pp = k % 14;
            check("pingpong_q", {5'd0, cnt}, (pp <= 7) ? pp[7:0] : 8'(14 - pp));
            if (k == 7 || k == 14)
                check("pingpong_pulse", {7'd0, dir_chg}, 8'd1);
        end
        check("sweep_down_m", {7'd0, m}, 8'd1);

        // Reset mid-sweep with m = 1, then the counter restarts upwards
        auto_en = 1'b0;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            step();
            check("post_rst_q", {5'd0, cnt}, k[7:0]);
        end

        // Manual press: m flips exactly at edge 3+DC after btn rises
        do_reset();
        btn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2 + DC) check("db_edge", {7'd0, btn_db}, 8'd1);
            if (k == 2 + DC) check("m_before_edge", {7'd0, m}, 8'd0);
            if (k == 3 + DC) check("m_at_edge", {7'd0, m}, 8'd1);
            if (k == 3 + DC) check("press_pulse", {7'd0, dir_chg}, 8'd1);
            if (k == 4 + DC) check("pulse_once", {7'd0, dir_chg}, 8'd0);
        end

        // Reset while btn_db = 1 and m = 1
        btn = 1'b0;
        do_reset();
        steps(2);

        // Press again, then release: release must not reverse
        btn = 1'b1;
        steps(10);
        check("press2_m", {7'd0, m}, 8'd1);
        btn = 1'b0;
        steps(12);
        check("release_m", {7'd0, m}, 8'd1);
        check("release_db", {7'd0, btn_db}, 8'd0);

        // Glitch of DC-1 synchronized cycles is rejected
        m_before = m;
        btn = 1'b1;
        steps(DC - 1);
        btn = 1'b0;
        steps(10);
        check("glitch_db", {7'd0, btn_db}, 8'd0);
        check("glitch_m", {7'd0, m}, {7'd0, m_before});

        // Collision: press lands on q = 6 in S_UP with auto_en = 1
        do_reset();
        auto_en = 1'b1;
        btn = 1'b1;
        steps(2 + DC);
        check("coll_q6", {5'd0, cnt}, 8'd6);
        step();
        check("coll_m", {7'd0, m}, 8'd1);
        check("coll_q7", {5'd0, cnt}, 8'd7);
        check("coll_pulse", {7'd0, dir_chg}, 8'd1);
        step();
        check("coll_q_back", {5'd0, cnt}, 8'd6);
        check("coll_single", {7'd0, m}, 8'd1);
        btn = 1'b0;
        steps(8);

        // Manual wrap: no auto, counter rolls 7 -> 0 with no reversal
        auto_en = 1'b0;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            check("wrap_q", {5'd0, cnt}, 8'(k % 8));
            check("wrap_m", {7'd0, m}, 8'd0);
            check("wrap_pulse", {7'd0, dir_chg}, 8'd0);
        end

        // Randomized traffic: button pulses of random length, auto toggling,
        // occasional mid-run resets.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 3) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 15) == 0) begin
                btn = 1'b0;
                do_reset();
            end
            btn = 1'b1;
            steps($urandom_range(1, 2 * DC + 2));
            btn = 1'b0;
            steps($urandom_range(1, 2 * DC + 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_count_dir_ctrl
